// File: rtl/sid_pkg.sv
// sid_pkg: shared SID scheduler types, widths and the DCA scaling reference
// Contents: sched_state_t, voice datapath widths, dca_scale() reference model.
package sid_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, COMMIT} sched_state_t;
  localparam int SID_WAVE_W = 12;
  localparam int SID_ENV_W = 8;
  localparam int SID_VOICE_W = 14;
  localparam int SID_OUT_SHIFT = 6;
  function automatic logic signed [SID_VOICE_W-1:0] dca_scale(
    input logic [SID_WAVE_W-1:0] wave,
    input logic [SID_ENV_W-1:0] env
  );
    logic signed [19:0] a, b, p;
    a = {{8{~wave[11]}}, ~wave[11], wave[10:0]};
    b = {12'd0, env};
    p = a * b;
    return SID_VOICE_W'(p >>> SID_OUT_SHIFT);
  endfunction
endpackage

// File: rtl/sid_dca_mul.sv
// sid_dca_mul: registered signed wave x envelope multiply, one clock latency
// Ports: clock; wave (offset-binary sample); env (unsigned envelope);
//        result (signed product >>> OUT_SHIFT, registered).
module sid_dca_mul #(
  parameter int WAVE_W = 12,
  parameter int ENV_W = 8,
  parameter int OUT_SHIFT = 6,
  localparam int P_W = WAVE_W + ENV_W,
  localparam int R_W = P_W - OUT_SHIFT
) (
  input  logic                  clock,
  input  logic [WAVE_W-1:0]     wave,
  input  logic [ENV_W-1:0]      env,
  output logic signed [R_W-1:0] result
);
  logic signed [P_W-1:0] a, b, p;
  always_comb begin
    a = P_W'($signed({~wave[WAVE_W-1], wave[WAVE_W-2:0]}));
    b = P_W'({1'b0, env});
    p = a * b;
  end
  always_ff @(posedge clock) result <= R_W'(p >>> OUT_SHIFT);
endmodule

// File: rtl/sid_dca_sched.sv
// sid_dca_sched: time-shares one DCA multiplier across all SID voices
// Ports: clock; reset_n (sync, active-low); ce_1m (sample strobe);
//        wave_in/env_in/mute (per-voice inputs, snapshotted on an accepted ce_1m);
//        voice_out/mix_out (committed scaled voices and their sum);
//        out_valid (commit pulse); busy (schedule running); overrun (sticky dropped ce_1m).
module sid_dca_sched
  import sid_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int WAVE_W = SID_WAVE_W,
  parameter int ENV_W = SID_ENV_W,
  parameter int OUT_SHIFT = SID_OUT_SHIFT,
  localparam int VOICE_W = WAVE_W + ENV_W - OUT_SHIFT,
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          ce_1m,
  input  logic [NUM_VOICES*WAVE_W-1:0]  wave_in,
  input  logic [NUM_VOICES*ENV_W-1:0]   env_in,
  input  logic [NUM_VOICES-1:0]         mute,
  output logic [NUM_VOICES*VOICE_W-1:0] voice_out,
  output logic [15:0]                   mix_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);
  sched_state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_d;
  logic vld_d, issue, accept;
  logic [NUM_VOICES*WAVE_W-1:0] wave_s;
  logic [NUM_VOICES*ENV_W-1:0] env_s;
  logic [NUM_VOICES-1:0] mute_s;
  logic [WAVE_W-1:0] mul_wave;
  logic [ENV_W-1:0] mul_env;
  logic signed [VOICE_W-1:0] mul_res;
  logic [NUM_VOICES*VOICE_W-1:0] stage, stage_nxt;
  logic signed [15:0] mix_nxt;
  always_ff @(posedge clock)
    state <= !reset_n ? IDLE : state_nxt;
  always_comb
    state_nxt = state == ISSUE ? (idx == IDX_W'(NUM_VOICES - 1) ? FLUSH : ISSUE) :
                state == FLUSH ? COMMIT :
                accept         ? ISSUE  : IDLE;
  always_comb begin
    issue = state == ISSUE;
    busy = issue || state == FLUSH;
    out_valid = state == COMMIT;
    accept = ce_1m && !busy;
  end
  always_ff @(posedge clock)
    if (accept) begin
      wave_s <= wave_in;
      env_s <= env_in;
      mute_s <= mute;
    end
  // A muted voice still takes its slot; a zero envelope yields a zero result.
  always_comb begin
    mul_wave = wave_s[idx*WAVE_W +: WAVE_W];
    mul_env = mute_s[idx] ? '0 : env_s[idx*ENV_W +: ENV_W];
  end
  sid_dca_mul #(.WAVE_W(WAVE_W), .ENV_W(ENV_W), .OUT_SHIFT(OUT_SHIFT)) u_mul (
    .clock  (clock),
    .wave   (mul_wave),
    .env    (mul_env),
    .result (mul_res)
  );
  // The product of the voice issued last clock lands in lane idx_d; the
  // commit reads this merged view so the final voice needs no extra cycle.
  always_comb begin
    stage_nxt = stage;
    if (vld_d) stage_nxt[idx_d*VOICE_W +: VOICE_W] = mul_res;
    mix_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      mix_nxt = mix_nxt + 16'($signed(stage_nxt[i*VOICE_W +: VOICE_W]));
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      idx <= '0;
      idx_d <= '0;
      vld_d <= 1'b0;
      stage <= '0;
      voice_out <= '0;
      mix_out <= '0;
      overrun <= 1'b0;
    end else begin
      idx <= issue ? idx + IDX_W'(1) : '0;
      idx_d <= idx;
      vld_d <= issue;
      stage <= stage_nxt;
      if (ce_1m && busy) overrun <= 1'b1;
      if (state == FLUSH) begin
        voice_out <= stage_nxt;
        mix_out <= mix_nxt;
      end
    end
endmodule

// File: tb/tb_sid_dca_sched.sv
// tb_sid_dca_sched: directed table and corner-case sequences for sid_dca_sched
module tb_sid_dca_sched;
  import sid_pkg::*;
  logic clock = 1'b0;
  logic reset_n, ce_1m;
  logic [35:0] wave_in;
  logic [23:0] env_in;
  logic [2:0] mute;
  logic [41:0] voice_out;
  logic [15:0] mix_out;
  logic out_valid, busy, overrun;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [35:0] wave;
    logic [23:0] env;
    logic [2:0] mute;
    int v0, v1, v2, mix;
  } vec_t;
  vec_t tbl[6];
  sid_dca_sched dut (
    .clock(clock), .reset_n(reset_n), .ce_1m(ce_1m),
    .wave_in(wave_in), .env_in(env_in), .mute(mute),
    .voice_out(voice_out), .mix_out(mix_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clock = ~clock;
  function automatic int lane(input int i);
    return int'($signed(voice_out[i*14 +: 14]));
  endfunction
  function automatic int mix();
    return int'($signed(mix_out));
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t x, input string nm);
    int lat;
    wave_in = x.wave;
    env_in = x.env;
    mute = x.mute;
    ce_1m = 1'b1;
    @(negedge clock);
    ce_1m = 1'b0;
    chk({nm, "_busy"}, int'(busy), 1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    chk({nm, "_latency"}, lat, 5);
    chk({nm, "_v0"}, lane(0), x.v0);
    chk({nm, "_v1"}, lane(1), x.v1);
    chk({nm, "_v2"}, lane(2), x.v2);
    chk({nm, "_mix"}, mix(), x.mix);
  endtask
  initial begin
    vec_t r;
    int seen;
    reset_n = 1'b0;
    ce_1m = 1'b0;
    wave_in = '1;
    env_in = '1;
    mute = '0;
    tbl[0] = '{36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 8156, 8156, 8156, 24468};
    tbl[1] = '{36'h000_000_000, 24'hFF_FF_FF, 3'b000, -8160, -8160, -8160, -24480};
    tbl[2] = '{36'h000_C00_800, 24'hFF_40_80, 3'b100, 0, 1024, 0, 1024};
    tbl[3] = '{36'h7FF_001_FFF, 24'h80_FF_01, 3'b000, 31, -8157, -2, -8128};
    tbl[4] = '{36'hA00_800_FFF, 24'h10_FF_00, 3'b000, 0, 0, 128, 128};
    tbl[5] = '{36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b111, 0, 0, 0, 0};
    // reset held across several strobes
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      ce_1m = 1'b1;
      @(negedge clock);
      ce_1m = 1'b0;
      repeat (6) begin
        seen += int'(out_valid);
        @(negedge clock);
      end
    end
    chk("rst_no_valid", seen, 0);
    chk("rst_voice", int'(voice_out != 0), 0);
    chk("rst_mix", mix(), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    @(negedge clock);
    // directed table
    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clock);
    end
    wave_in = '0;
    env_in = '1;
    mute = '0;
    repeat (3) @(negedge clock);
    chk("hold_valid", int'(out_valid), 0);
    chk("hold_v1", lane(1), 0);
    // reference-model vectors
    for (int k = 0; k < 3; k++) begin
      r.wave = {4'($urandom()), $urandom()};
      r.env = 24'($urandom());
      r.mute = 3'($urandom());
      r.v0 = r.mute[0] ? 0 : int'(dca_scale(r.wave[11:0], r.env[7:0]));
      r.v1 = r.mute[1] ? 0 : int'(dca_scale(r.wave[23:12], r.env[15:8]));
      r.v2 = r.mute[2] ? 0 : int'(dca_scale(r.wave[35:24], r.env[23:16]));
      r.mix = r.v0 + r.v1 + r.v2;
      run_vec(r, $sformatf("rnd%0d", k));
      @(negedge clock);
    end
    // snapshot isolation: inputs change two clocks after the strobe
    wave_in = '1;
    env_in = '1;
    mute = '0;
    ce_1m = 1'b1;
    @(negedge clock);
    ce_1m = 1'b0;
    @(negedge clock);
    wave_in = '0;
    env_in = 24'h01_01_01;
    mute = 3'b111;
    repeat (3) @(negedge clock);
    chk("iso_valid", int'(out_valid), 1);
    chk("iso_v0", lane(0), 8156);
    chk("iso_v2", lane(2), 8156);
    chk("iso_mix", mix(), 24468);
    repeat (2) @(negedge clock);
    // back-to-back strobes at the minimum period
    seen = 0;
    for (int j = 0; j < 26; j++) begin
      if (j % 5 == 0 && j >= 5 && j <= 20) begin
        chk($sformatf("b2b_valid%0d", j), int'(out_valid), 1);
        chk($sformatf("b2b_mix%0d", j), mix(), ((j / 5 - 1) % 2 == 0) ? 24468 : -24480);
      end
      seen += int'(out_valid);
      ce_1m = (j % 5 == 0 && j < 20);
      wave_in = ((j / 5) % 2 == 0) ? '1 : '0;
      env_in = '1;
      mute = '0;
      @(negedge clock);
    end
    ce_1m = 1'b0;
    chk("b2b_pulses", seen, 4);
    chk("b2b_overrun", int'(overrun), 0);
    // strobe while busy is dropped
    wave_in = '1;
    env_in = '1;
    ce_1m = 1'b1;
    @(negedge clock);
    ce_1m = 1'b0;
    @(negedge clock);
    ce_1m = 1'b1;
    wave_in = '0;
    @(negedge clock);
    ce_1m = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    repeat (2) @(negedge clock);
    chk("ovr_valid", int'(out_valid), 1);
    chk("ovr_mix", mix(), 24468);
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      seen += int'(out_valid);
    end
    chk("ovr_no_extra", seen, 0);
    run_vec(tbl[1], "ovr_next");
    chk("ovr_sticky", int'(overrun), 1);
    repeat (2) @(negedge clock);
    // reset three clocks into a schedule
    wave_in = '1;
    env_in = '1;
    ce_1m = 1'b1;
    @(negedge clock);
    ce_1m = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      seen += int'(out_valid);
      @(negedge clock);
    end
    chk("mid_rst_no_valid", seen, 0);
    chk("mid_rst_voice", int'(voice_out != 0), 0);
    chk("mid_rst_mix", mix(), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    run_vec(tbl[2], "post_rst");
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
